fifo_ctrl: RTL and testbench

FIFO_CTRL -- requirements
Module: fifo_ctrl

---
 rtl/fifo_ctrl.sv | 137 +++++++++++++
 tb/tb_fifo_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: circular-buffer controller for an external dual-port memory.
// Port A is the write-only side, port B the read-only side. The controller
// owns the pointers, the occupancy count, the flags and the sticky error bits.
//
// Request semantics: push and pop are requests sampled at each rising edge.
// A push is taken only when the FIFO is not full and a pop is taken only when
// it is not empty. A request that is not taken has no effect on the pointers,
// the count or the memory. A refused push sets overflow and a refused pop sets
// underflow. A taken pop returns its word one cycle later, qualified by
// valid_out. There is no back-pressure on the output side.
module fifo_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6,
    parameter int AF_THR = 56,
    parameter int AE_THR = 8
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] q_b,
    output logic              we_a,
    output logic [ADDR_W-1:0] addr_a,
    output logic [DATA_W-1:0] data_a,
    output logic              we_b,
    output logic [ADDR_W-1:0] addr_b,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam int              DEPTH_I = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH   = DEPTH_I[ADDR_W:0];
    localparam logic [ADDR_W:0] AF_LVL  = AF_THR[ADDR_W:0];
    localparam logic [ADDR_W:0] AE_LVL  = AE_THR[ADDR_W:0];
    localparam logic [ADDR_W:0] ONE     = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   cnt_q;
    logic              valid_q;
    logic              ovf_q;
    logic              unf_q;
    logic              push_ok;
    logic              pop_ok;
    logic              push_rej;
    logic              pop_rej;

    // Acceptance decisions. Both are masked by reset so that requests made
    // while reset is asserted never reach the memory. Because a pop is only
    // taken when empty is low, an empty FIFO never bypasses a word that is
    // pushed in the same cycle.
    always_comb begin
        push_ok  = 1'b0;
        pop_ok   = 1'b0;
        push_rej = 1'b0;
        pop_rej  = 1'b0;
        if (reset_L) begin
            push_ok  = push & ~full;
            pop_ok   = pop & ~empty;
            push_rej = push & full;
            pop_rej  = pop & empty;
        end
    end

    // Occupancy flags, decoded directly from the registered count.
    always_comb begin
        full         = (cnt_q == DEPTH);
        empty        = (cnt_q == '0);
        almost_full  = (cnt_q >= AF_LVL);
        almost_empty = (cnt_q <= AE_LVL);
    end

    // Memory port drive. Port B never writes. Its address is the read
    // pointer, which the memory samples on the edge that accepts the pop.
    always_comb begin
        we_a      = push_ok;
        addr_a    = wr_ptr;
        data_a    = data_in;
        we_b      = 1'b0;
        addr_b    = rd_ptr;
        data_out  = q_b;
        valid_out = valid_q;
        count     = cnt_q;
        overflow  = ovf_q;
        underflow = unf_q;
    end

    // Pointer and count update. The pointers wrap naturally at 2^ADDR_W. A
    // write can never land on an unread word, because a push is refused when
    // full.
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push_ok && !pop_ok) begin
                cnt_q <= cnt_q + ONE;
            end else if (pop_ok && !push_ok) begin
                cnt_q <= cnt_q - ONE;
            end
        end
    end

    // Output qualifier and sticky error flags.
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            valid_q <= pop_ok;
            if (push_rej) begin
                ovf_q <= 1'b1;
            end
            if (pop_rej) begin
                unf_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: directed and random checks of fifo_ctrl. The bench contains a
// dual-port memory model and a queue-based reference model of the FIFO.
module tb_fifo_ctrl;

    logic       clk;
    logic       reset_L;
    logic       push;
    logic       pop;
    logic [7:0] data_in;
    logic [7:0] q_b;
    logic       we_a;
    logic [5:0] addr_a;
    logic [7:0] data_a;
    logic       we_b;
    logic [5:0] addr_b;
    logic [7:0] data_out;
    logic       valid_out;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [6:0] count;
    logic       overflow;
    logic       underflow;

    int total = 0;
    int bad   = 0;

    // Reference state: the queue holds the stored words in FIFO order.
    logic [7:0] exp_q[$];
    logic       m_ovf;
    logic       m_unf;
    int         n_push;
    int         n_pop;

    logic [7:0] mem [64];

    fifo_ctrl dut (
        .clk(clk), .reset_L(reset_L), .push(push), .pop(pop),
        .data_in(data_in), .q_b(q_b), .we_a(we_a), .addr_a(addr_a),
        .data_a(data_a), .we_b(we_b), .addr_b(addr_b), .data_out(data_out),
        .valid_out(valid_out), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .count(count), .overflow(overflow), .underflow(underflow)
    );

    // Clock generation.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous dual-port memory with one cycle of read latency.
    always @(posedge clk) begin
        if (we_a) mem[addr_a] <= data_a;
        q_b <= mem[addr_b];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare the count, the flags and the sticky bits with the model.
    task automatic chk_state(input string where);
        int n;
        n = exp_q.size();
        chk({where, ":count"}, 32'(count), n);
        chk({where, ":full"}, 32'(full), 32'(n == 64));
        chk({where, ":empty"}, 32'(empty), 32'(n == 0));
        chk({where, ":almost_full"}, 32'(almost_full), 32'(n >= 56));
        chk({where, ":almost_empty"}, 32'(almost_empty), 32'(n <= 8));
        chk({where, ":overflow"}, 32'(overflow), 32'(m_ovf));
        chk({where, ":underflow"}, 32'(underflow), 32'(m_unf));
    endtask

    // Run one cycle with the given requests and check it against the model.
    task automatic step(input logic p, input logic q, input logic [7:0] d);
        logic       push_ok;
        logic       pop_ok;
        logic [7:0] exp_word;
        @(negedge clk);
        reset_L = 1'b1;
        push    = p;
        pop     = q;
        data_in = d;
        #1;
        push_ok  = p && (exp_q.size() < 64);
        pop_ok   = q && (exp_q.size() > 0);
        exp_word = 8'h00;
        chk("pre", 32'(we_a), 32'(push_ok));
        chk("we_b", 32'(we_b), 0);
        chk("addr_b", 32'(addr_b), n_pop % 64);
        if (push_ok) begin
            chk("addr_a", 32'(addr_a), n_push % 64);
            chk("data_a", 32'(data_a), 32'(d));
        end
        chk_state("pre");
        if (pop_ok) begin
            exp_word = exp_q.pop_front();
            n_pop++;
        end
        if (push_ok) begin
            exp_q.push_back(d);
            n_push++;
        end
        if (p && !push_ok) m_ovf = 1'b1;
        if (q && !pop_ok)  m_unf = 1'b1;
        @(posedge clk);
        #1;
        chk("valid_out", 32'(valid_out), 32'(pop_ok));
        if (pop_ok) chk("data_out", 32'(data_out), 32'(exp_word));
        chk_state("post");
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_L = 1'b0;
        push    = 1'($urandom_range(0, 1));
        pop     = 1'($urandom_range(0, 1));
        data_in = 8'($urandom);
        #1;
        chk("rst_we_a", 32'(we_a), 0);
        @(posedge clk);
        #1;
        exp_q.delete();
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
        n_push = 0;
        n_pop  = 0;
        chk("rst_valid_out", 32'(valid_out), 0);
        chk_state("rst");
    endtask

    initial begin
        reset_L = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        data_in = 8'h00;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
        n_push  = 0;
        n_pop   = 0;

        // Basic push/pop sequence, with the first requests made right after reset.
        do_reset();
        step(1, 0, 8'h0A);
        step(1, 0, 8'hAA);
        step(0, 1, 8'h00);
        step(0, 1, 8'h00);
        step(0, 0, 8'h00);
        chk("basic_empty", 32'(empty), 1);

        // Fill until full, then push once more to overflow.
        do_reset();
        for (int i = 0; i < 64; i++) step(1, 0, 8'(i));
        chk("fill_full", 32'(full), 1);
        step(1, 0, 8'h5A);
        chk("ovf_set", 32'(overflow), 1);
        chk("ovf_count", 32'(count), 64);
        // Simultaneous push and pop when full: only the pop is taken.
        step(1, 1, 8'hC3);
        chk("full_pp_count", 32'(count), 63);
        for (int i = 0; i < 63; i++) step(0, 1, 8'h00);

        // Underflow, followed by normal operation.
        do_reset();
        step(0, 1, 8'h00);
        chk("unf_set", 32'(underflow), 1);
        step(1, 0, 8'h3C);
        step(0, 1, 8'h00);

        // Simultaneous push and pop when empty: only the push is taken.
        do_reset();
        step(1, 1, 8'h77);
        chk("empty_pp_count", 32'(count), 1);
        step(0, 1, 8'h00);

        // Steady-state push and pop at count 5, wrapping the pointers twice.
        do_reset();
        for (int i = 0; i < 5; i++) step(1, 0, 8'($urandom));
        for (int i = 0; i < 130; i++) step(1, 1, 8'($urandom));
        chk("steady_count", 32'(count), 5);

        // Threshold sweep up to full and back down to empty.
        do_reset();
        for (int i = 0; i < 64; i++) step(1, 0, 8'($urandom));
        for (int i = 0; i < 64; i++) step(0, 1, 8'h00);

        // Random traffic with changing bias, including a reset mid-stream.
        do_reset();
        for (int r = 0; r < 1500; r++) begin
            int bias;
            bias = (r / 250) % 3;
            step(1'($urandom_range(0, 9) < (bias == 0 ? 7 : (bias == 1 ? 3 : 5))),
                 1'($urandom_range(0, 9) < (bias == 0 ? 3 : (bias == 1 ? 7 : 5))),
                 8'($urandom));
            if (r == 700) do_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
